// File: rtl/br_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : br_arbiter
// Purpose  : Two-port round-robin burst arbiter in front of a PSRAM
//            controller. Issues one command per burst, streams write beats
//            from the owning port, routes read beats back to it, and enforces
//            an idle gap between bursts.
// Revision : 1.0 - initial release
// ============================================================================
module br_arbiter #(
  parameter int BURST_BEATS = 4,
  parameter int CMD_GAP     = 14,
  parameter int ADDR_WIDTH  = 21
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_calib,
  // port 0
  input  logic                  p0_req,
  input  logic                  p0_cmd,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [63:0]           p0_wr_data,
  input  logic [7:0]            p0_data_mask,
  output logic                  p0_ack,
  output logic                  p0_wr_next,
  output logic [63:0]           p0_rd_data,
  output logic                  p0_rd_data_valid,
  output logic                  p0_done,
  // port 1
  input  logic                  p1_req,
  input  logic                  p1_cmd,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [63:0]           p1_wr_data,
  input  logic [7:0]            p1_data_mask,
  output logic                  p1_ack,
  output logic                  p1_wr_next,
  output logic [63:0]           p1_rd_data,
  output logic                  p1_rd_data_valid,
  output logic                  p1_done,
  // controller side
  output logic                  br_cmd,
  output logic                  br_cmd_en,
  output logic [ADDR_WIDTH-1:0] br_addr,
  output logic [63:0]           br_wr_data,
  output logic [7:0]            br_data_mask,
  input  logic [63:0]           br_rd_data,
  input  logic                  br_rd_data_valid,
  output logic                  err
);

  localparam int c_beat_w = $clog2(BURST_BEATS) + 1;
  localparam int c_gap_w  = $clog2(CMD_GAP) + 1;
  localparam logic [c_beat_w-1:0] c_beat_last = c_beat_w'(BURST_BEATS - 1);
  localparam logic [c_gap_w-1:0]  c_gap_last  = c_gap_w'(CMD_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_beat_w-1:0]   r_beat;
  logic [c_gap_w-1:0]    r_gap;
  logic                  r_last_grant;   // 1: port 1 was granted last
  logic                  r_owner;        // port that owns the current burst
  logic                  r_err;
  logic                  r_cmd_en;
  logic                  r_cmd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_done0;
  logic                  r_done1;

  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_sel_cmd;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic                  w_wr_beat;
  logic                  w_rd_route;
  logic                  w_last_beat;

  // Round-robin grant, only evaluated while idle and calibrated
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == ST_IDLE && init_calib) begin
      if (p0_req && p1_req) begin
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
      end else begin
        w_grant0 = p0_req;
        w_grant1 = p1_req;
      end
    end
  end

  assign w_sel_cmd  = w_grant1 ? p1_cmd  : p0_cmd;
  assign w_sel_addr = w_grant1 ? p1_addr : p0_addr;

  // Every WRITE cycle carries one beat; READ beats arrive with the valid strobe
  assign w_wr_beat   = (r_state == ST_WRITE);
  assign w_rd_route  = br_rd_data_valid && (r_state == ST_READ);
  assign w_last_beat = (r_beat == c_beat_last);

  // Burst sequencing, arbitration bookkeeping and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_gap        <= '0;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_err        <= 1'b0;
      r_cmd_en     <= 1'b0;
      r_cmd        <= 1'b0;
      r_addr       <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
    end else begin
      r_cmd_en <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;

      // Read data outside a read burst has no owner: flag it, never route it
      if (br_rd_data_valid && r_state != ST_READ) begin
        r_err <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_owner      <= w_grant1;
            r_last_grant <= w_grant1;
            r_cmd        <= w_sel_cmd;
            r_addr       <= w_sel_addr;
            r_cmd_en     <= 1'b1;
            r_ack0       <= w_grant0;
            r_ack1       <= w_grant1;
            r_beat       <= '0;
            r_state      <= w_sel_cmd ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE, ST_READ: begin
          if (w_wr_beat || br_rd_data_valid) begin
            if (w_last_beat) begin
              r_done0 <= ~r_owner;
              r_done1 <= r_owner;
              r_gap   <= '0;
              r_state <= (CMD_GAP == 0) ? ST_IDLE : ST_GAP;
            end else begin
              r_beat <= r_beat + c_beat_w'(1);
            end
          end
        end
        ST_GAP: begin
          if (r_gap == c_gap_last) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + c_gap_w'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Write beat mux from the owning port; zero outside beat cycles
  always_comb begin
    br_wr_data   = '0;
    br_data_mask = '0;
    if (w_wr_beat) begin
      br_wr_data   = r_owner ? p1_wr_data   : p0_wr_data;
      br_data_mask = r_owner ? p1_data_mask : p0_data_mask;
    end
  end

  assign br_cmd_en        = r_cmd_en;
  assign br_cmd           = r_cmd;
  assign br_addr          = r_addr;
  assign err              = r_err;

  assign p0_ack           = r_ack0;
  assign p1_ack           = r_ack1;
  assign p0_done          = r_done0;
  assign p1_done          = r_done1;
  assign p0_wr_next       = w_wr_beat && !r_owner;
  assign p1_wr_next       = w_wr_beat &&  r_owner;

  assign p0_rd_data       = br_rd_data;
  assign p1_rd_data       = br_rd_data;
  assign p0_rd_data_valid = w_rd_route && !r_owner;
  assign p1_rd_data_valid = w_rd_route &&  r_owner;

endmodule
`default_nettype wire

// File: tb/tb_br_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_br_arbiter
// Purpose  : Directed self-checking bench for br_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_br_arbiter;

  logic        clk;
  logic        rst_n;
  logic        init_calib;
  logic        p0_req, p0_cmd, p1_req, p1_cmd;
  logic [20:0] p0_addr, p1_addr;
  logic [63:0] p0_wr_data, p1_wr_data;
  logic [7:0]  p0_data_mask, p1_data_mask;
  logic        p0_ack, p0_wr_next, p0_rd_data_valid, p0_done;
  logic        p1_ack, p1_wr_next, p1_rd_data_valid, p1_done;
  logic [63:0] p0_rd_data, p1_rd_data;
  logic        br_cmd, br_cmd_en;
  logic [20:0] br_addr;
  logic [63:0] br_wr_data;
  logic [7:0]  br_data_mask;
  logic [63:0] br_rd_data;
  logic        br_rd_data_valid;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Every output that reset must clear, flattened for a single check
  logic [103:0] outs_flat;
  assign outs_flat = {br_cmd_en, br_cmd, br_addr, br_wr_data, br_data_mask,
                      p0_ack, p1_ack, p0_done, p1_done, p0_wr_next, p1_wr_next,
                      p0_rd_data_valid, p1_rd_data_valid, err};

  logic        rd_valid_vec [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [63:0] rd_beat_vec  [6] = '{64'hAA, 64'hBB, 64'h0, 64'hCC, 64'hDD, 64'h0};

  br_arbiter #(.BURST_BEATS(4), .CMD_GAP(14), .ADDR_WIDTH(21)) dut (
    .clk(clk), .rst_n(rst_n), .init_calib(init_calib),
    .p0_req(p0_req), .p0_cmd(p0_cmd), .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
    .p0_data_mask(p0_data_mask), .p0_ack(p0_ack), .p0_wr_next(p0_wr_next),
    .p0_rd_data(p0_rd_data), .p0_rd_data_valid(p0_rd_data_valid), .p0_done(p0_done),
    .p1_req(p1_req), .p1_cmd(p1_cmd), .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
    .p1_data_mask(p1_data_mask), .p1_ack(p1_ack), .p1_wr_next(p1_wr_next),
    .p1_rd_data(p1_rd_data), .p1_rd_data_valid(p1_rd_data_valid), .p1_done(p1_done),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
    .br_rd_data_valid(br_rd_data_valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive point just after the active edge, sample point on the falling edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    sample();
    total++; if (outs_flat !== '0) begin bad++; $display("FAIL reset_outputs: got %0h want 0", outs_flat); end
    step();
    rst_n = 1'b1;
    sample();
    total++; if (br_cmd_en !== 1'b0) begin bad++; $display("FAIL post_reset_cmd_en: got %0b want 0", br_cmd_en); end
  endtask

  task automatic test_write();
    int  n;
    bit  found;
    step();
    p0_req = 1'b1; p0_cmd = 1'b1; p0_addr = 21'h000040;
    p0_wr_data = 64'h1; p0_data_mask = 8'hA0;
    sample();
    total++; if (br_cmd_en !== 1'b0) begin bad++; $display("FAIL wr_req_cycle_cmd_en: got %0b want 0", br_cmd_en); end
    for (int k = 0; k < 4; k++) begin
      step();
      p0_wr_data   = 64'(k + 1);
      p0_data_mask = 8'(8'hA0 + k);
      if (k == 1) p0_req = 1'b0;
      sample();
      total++; if (br_cmd_en !== (k == 0)) begin bad++; $display("FAIL wr_cmd_en beat%0d: got %0b want %0b", k, br_cmd_en, (k == 0)); end
      total++; if (p0_wr_next !== 1'b1 || p1_wr_next !== 1'b0) begin bad++; $display("FAIL wr_next beat%0d: got %0b%0b want 10", k, p0_wr_next, p1_wr_next); end
      total++; if (br_wr_data !== 64'(k + 1)) begin bad++; $display("FAIL wr_data beat%0d: got %0h want %0h", k, br_wr_data, k + 1); end
      total++; if (br_data_mask !== 8'(8'hA0 + k)) begin bad++; $display("FAIL wr_mask beat%0d: got %0h want %0h", k, br_data_mask, 8'hA0 + k); end
      total++; if (p0_done !== 1'b0) begin bad++; $display("FAIL wr_early_done beat%0d: got %0b want 0", k, p0_done); end
      if (k == 0) begin
        total++; if (br_cmd !== 1'b1 || br_addr !== 21'h000040) begin bad++; $display("FAIL wr_cmd_addr: got %0b/%0h want 1/40", br_cmd, br_addr); end
        total++; if (p0_ack !== 1'b1 || p1_ack !== 1'b0) begin bad++; $display("FAIL wr_ack: got %0b%0b want 10", p0_ack, p1_ack); end
      end else begin
        total++; if (p0_ack !== 1'b0) begin bad++; $display("FAIL wr_ack_width beat%0d: got %0b want 0", k, p0_ack); end
      end
    end
    step();
    p0_wr_data = 64'h55; p0_data_mask = 8'hFF;
    p1_req = 1'b1; p1_cmd = 1'b0; p1_addr = 21'h1FFFE0;
    sample();
    total++; if (p0_done !== 1'b1 || p1_done !== 1'b0) begin bad++; $display("FAIL wr_done: got %0b%0b want 10", p0_done, p1_done); end
    total++; if (p0_wr_next !== 1'b0) begin bad++; $display("FAIL wr_next_after: got %0b want 0", p0_wr_next); end
    total++; if (br_wr_data !== 64'h0 || br_data_mask !== 8'h00) begin bad++; $display("FAIL wr_idle_bus: got %0h/%0h want 0/0", br_wr_data, br_data_mask); end
    n = 0; found = 1'b0;
    while (!found && n < 40) begin
      step(); sample(); n++;
      if (br_cmd_en === 1'b1) found = 1'b1;
    end
    total++; if (!found || n != 15) begin bad++; $display("FAIL cmd_spacing: got %0d want 19 (found=%0b)", n + 4, found); end
  endtask

  task automatic test_read();
    int cnt;
    total++; if (p1_ack !== 1'b1 || p0_ack !== 1'b0) begin bad++; $display("FAIL rd_ack: got %0b%0b want 01", p0_ack, p1_ack); end
    total++; if (br_cmd !== 1'b0 || br_addr !== 21'h1FFFE0) begin bad++; $display("FAIL rd_cmd_addr: got %0b/%0h want 0/1fffe0", br_cmd, br_addr); end
    total++; if (p1_wr_next !== 1'b0 || br_wr_data !== 64'h0) begin bad++; $display("FAIL rd_no_wr: got %0b/%0h want 0/0", p1_wr_next, br_wr_data); end
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) p1_req = 1'b0;
      br_rd_data_valid = rd_valid_vec[i];
      br_rd_data       = rd_beat_vec[i];
      sample();
      if (p1_rd_data_valid === 1'b1) cnt++;
      total++; if (p1_rd_data_valid !== rd_valid_vec[i]) begin bad++; $display("FAIL rd_valid cyc%0d: got %0b want %0b", i, p1_rd_data_valid, rd_valid_vec[i]); end
      total++; if (p0_rd_data_valid !== 1'b0) begin bad++; $display("FAIL rd_p0_valid cyc%0d: got %0b want 0", i, p0_rd_data_valid); end
      total++; if (p1_rd_data !== rd_beat_vec[i] || p0_rd_data !== rd_beat_vec[i]) begin bad++; $display("FAIL rd_data cyc%0d: got %0h/%0h want %0h", i, p0_rd_data, p1_rd_data, rd_beat_vec[i]); end
      total++; if (p1_done !== (i == 5)) begin bad++; $display("FAIL rd_done cyc%0d: got %0b want %0b", i, p1_done, (i == 5)); end
    end
    total++; if (cnt != 4) begin bad++; $display("FAIL rd_beat_count: got %0d want 4", cnt); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rd_err: got %0b want 0", err); end
  endtask

  task automatic test_round_robin();
    int  n;
    bit  found;
    int  exp_port;
    step();
    p0_req = 1'b1; p0_cmd = 1'b1; p0_addr = 21'h000100;
    p1_req = 1'b1; p1_cmd = 1'b1; p1_addr = 21'h000200;
    for (int b = 0; b < 4; b++) begin
      exp_port = b % 2;
      n = 0; found = 1'b0;
      while (!found && n < 60) begin
        step(); sample(); n++;
        if (br_cmd_en === 1'b1) found = 1'b1;
      end
      total++; if (!found) begin bad++; $display("FAIL rr_timeout burst%0d: got none want cmd_en", b); end
      total++; if (p0_ack !== (exp_port == 0) || p1_ack !== (exp_port == 1)) begin bad++; $display("FAIL rr_order burst%0d: got %0b%0b want port %0d", b, p0_ack, p1_ack, exp_port); end
      total++; if (br_addr !== ((exp_port == 0) ? 21'h000100 : 21'h000200)) begin bad++; $display("FAIL rr_addr burst%0d: got %0h want port %0d addr", b, br_addr, exp_port); end
    end
    step();
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (25) step();
  endtask

  task automatic test_calib();
    step();
    init_calib = 1'b0;
    p0_req = 1'b1; p0_cmd = 1'b1; p0_addr = 21'h000300;
    for (int i = 0; i < 50; i++) begin
      sample();
      total++; if (br_cmd_en !== 1'b0 || p0_ack !== 1'b0) begin bad++; $display("FAIL calib_block cyc%0d: got %0b want 0", i, br_cmd_en); end
      step();
    end
    init_calib = 1'b1;
    sample();
    total++; if (br_cmd_en !== 1'b0) begin bad++; $display("FAIL calib_rise_same: got %0b want 0", br_cmd_en); end
    step(); sample();
    total++; if (br_cmd_en !== 1'b1 || p0_ack !== 1'b1) begin bad++; $display("FAIL calib_grant: got %0b/%0b want 1/1", br_cmd_en, p0_ack); end
    step();
    p0_req = 1'b0;
    repeat (25) step();
  endtask

  task automatic test_err_and_reset();
    br_rd_data_valid = 1'b1; br_rd_data = 64'h77;
    sample();
    total++; if (p0_rd_data_valid !== 1'b0 || p1_rd_data_valid !== 1'b0) begin bad++; $display("FAIL idle_valid_route: got %0b%0b want 00", p0_rd_data_valid, p1_rd_data_valid); end
    step();
    br_rd_data_valid = 1'b0;
    sample();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %0b want 1", err); end
    repeat (5) step();
    sample();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0b want 1", err); end
    step();
    p1_req = 1'b1; p1_cmd = 1'b0; p1_addr = 21'h001234;
    sample();
    step(); sample();
    total++; if (br_cmd_en !== 1'b1 || p1_ack !== 1'b1) begin bad++; $display("FAIL rst_rd_grant: got %0b/%0b want 1/1", br_cmd_en, p1_ack); end
    step();
    p1_req = 1'b0; br_rd_data_valid = 1'b1; br_rd_data = 64'h11;
    sample();
    total++; if (p1_rd_data_valid !== 1'b1) begin bad++; $display("FAIL rst_rd_beat1: got %0b want 1", p1_rd_data_valid); end
    step();
    br_rd_data = 64'h22; rst_n = 1'b0;
    #1;
    total++; if (outs_flat !== '0) begin bad++; $display("FAIL midburst_reset: got %0h want 0", outs_flat); end
    sample();
    step();
    rst_n = 1'b1; br_rd_data_valid = 1'b0;
    p0_req = 1'b1; p0_cmd = 1'b0; p0_addr = 21'h000555;
    sample();
    total++; if (p1_done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL post_reset_quiet: got %0b/%0b want 0/0", p1_done, err); end
    step(); sample();
    total++; if (br_cmd_en !== 1'b1 || p0_ack !== 1'b1 || br_addr !== 21'h000555) begin bad++; $display("FAIL post_reset_grant: got %0b/%0b/%0h want 1/1/555", br_cmd_en, p0_ack, br_addr); end
    total++; if (p1_done !== 1'b0) begin bad++; $display("FAIL abandoned_done: got %0b want 0", p1_done); end
  endtask

  initial begin
    rst_n = 1'b0; init_calib = 1'b1;
    p0_req = 1'b0; p0_cmd = 1'b0; p0_addr = '0; p0_wr_data = '0; p0_data_mask = '0;
    p1_req = 1'b0; p1_cmd = 1'b0; p1_addr = '0; p1_wr_data = '0; p1_data_mask = '0;
    br_rd_data = '0; br_rd_data_valid = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_calib();
    test_err_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
